// File: rtl/tetris_board_mem_if.sv
// Playfield storage bus between the Tetris game controller and the board memory.
// Groups the access port (cell read/write), the display read port and the
// row-check / row-clear command handshakes.
//   master : game controller / VGA side (drives requests and addresses)
//   slave  : tetris_board_mem (returns read data, done pulses, busy)
interface tetris_board_mem_if;
    // Access port
    logic       sram_we;
    logic       sram_re;
    logic [4:0] curr_x;
    logic [5:0] curr_y;
    logic [2:0] color_w;
    logic [2:0] sram_color;
    logic       rd_valid;
    // Display port
    logic [4:0] disp_x;
    logic [5:0] disp_y;
    logic [2:0] disp_color;
    // Row-full check engine
    logic       chk_req;
    logic [5:0] chk_y;
    logic       chk_done;
    logic       chk_full;
    // Row clear-and-shift engine
    logic       clr_req;
    logic [5:0] clr_y;
    logic       clr_done;
    logic       busy;

    modport master (
        output sram_we, sram_re, curr_x, curr_y, color_w,
        output disp_x, disp_y,
        output chk_req, chk_y, clr_req, clr_y,
        input  sram_color, rd_valid, disp_color,
        input  chk_done, chk_full, clr_done, busy
    );

    modport slave (
        input  sram_we, sram_re, curr_x, curr_y, color_w,
        input  disp_x, disp_y,
        input  chk_req, chk_y, clr_req, clr_y,
        output sram_color, rd_valid, disp_color,
        output chk_done, chk_full, clr_done, busy
    );
endinterface

// File: rtl/tetris_board_mem.sv
// Tetris playfield storage. Holds one 3-bit colour per cell, serves the
// controller's cell reads/writes, runs a free-running display read port and
// two multi-cycle engines: row-full check and row clear-and-shift.
// After reset the whole board is wiped to EMPTY before the access port opens.
// Ports:
//   clk   : single clock, posedge
//   reset : asynchronous, active-high; aborts any engine and rewipes the board
//   bus   : tetris_board_mem_if.slave (access, display, check, clear, busy)
module tetris_board_mem #(
    parameter int         COLS  = 21,
    parameter int         ROWS  = 42,
    parameter logic [2:0] EMPTY = 3'd7,
    parameter logic [2:0] WALL  = 3'd0
) (
    input  logic              clk,
    input  logic              reset,
    tetris_board_mem_if.slave bus
);

    localparam int CELLS = COLS * ROWS;
    localparam int AW    = $clog2(CELLS);

    typedef enum logic [2:0] {
        S_WIPE,
        S_IDLE,
        S_CHECK,
        S_SHIFT_RD,
        S_SHIFT_WR,
        S_FILL_TOP,
        S_DONE
    } state_t;

    logic [2:0]    mem [CELLS];
    state_t        state;
    logic [AW-1:0] wipe_idx;
    logic [4:0]    x;          // engine column
    logic [5:0]    row;        // engine row (check row, or shift destination row)
    logic [2:0]    latch;      // cell value carried from S_SHIFT_RD to S_SHIFT_WR
    logic          acc;        // running "all cells occupied" flag for the check

    logic          mem_we;
    logic [AW-1:0] mem_waddr;
    logic [2:0]    mem_wdata;
    logic [AW-1:0] eng_raddr;
    logic [2:0]    eng_rd;
    logic [2:0]    acc_rd;
    logic [2:0]    disp_rd;

    function automatic logic in_range(input logic [4:0] cx, input logic [5:0] cy);
        return (int'(cx) < COLS) && (int'(cy) < ROWS);
    endfunction

    // Row-major linear address, x fastest.
    function automatic logic [AW-1:0] cell_addr(input logic [5:0] cy, input logic [4:0] cx);
        return AW'(int'(cy) * COLS + int'(cx));
    endfunction

    // Engine read port: the shift reads the row above the destination row.
    assign eng_raddr = (state == S_SHIFT_RD) ? cell_addr(row - 6'd1, x) : cell_addr(row, x);
    assign eng_rd    = mem[eng_raddr];
    assign acc_rd    = in_range(bus.curr_x, bus.curr_y) ?
                       mem[cell_addr(bus.curr_y, bus.curr_x)] : WALL;
    assign disp_rd   = in_range(bus.disp_x, bus.disp_y) ?
                       mem[cell_addr(bus.disp_y, bus.disp_x)] : WALL;

    // Single write port shared by the wipe, the access port and the clear engine;
    // the FSM state decides who owns it.
    always_comb begin
        mem_we    = 1'b0;
        mem_waddr = '0;
        mem_wdata = EMPTY;
        case (state)
            S_WIPE: begin
                mem_we    = 1'b1;
                mem_waddr = wipe_idx;
            end
            S_IDLE: begin
                mem_we    = bus.sram_we && in_range(bus.curr_x, bus.curr_y);
                mem_waddr = cell_addr(bus.curr_y, bus.curr_x);
                mem_wdata = bus.color_w;
            end
            S_SHIFT_WR: begin
                mem_we    = 1'b1;
                mem_waddr = cell_addr(row, x);
                mem_wdata = latch;
            end
            S_FILL_TOP: begin
                mem_we    = 1'b1;
                mem_waddr = AW'(x);
            end
            default: ;
        endcase
    end

    // Board storage has no reset; the wipe state clears it after every reset.
    always_ff @(posedge clk) begin
        if (mem_we) mem[mem_waddr] <= mem_wdata;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) bus.disp_color <= EMPTY;
        else       bus.disp_color <= disp_rd;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state          <= S_WIPE;
            wipe_idx       <= '0;
            x              <= '0;
            row            <= '0;
            latch          <= EMPTY;
            acc            <= 1'b0;
            bus.busy       <= 1'b1;
            bus.rd_valid   <= 1'b0;
            bus.sram_color <= EMPTY;
            bus.chk_done   <= 1'b0;
            bus.chk_full   <= 1'b0;
            bus.clr_done   <= 1'b0;
        end else begin
            bus.chk_done <= 1'b0;
            bus.clr_done <= 1'b0;
            bus.rd_valid <= 1'b0;
            case (state)
                S_WIPE: begin
                    if (wipe_idx == AW'(CELLS - 1)) begin
                        state    <= S_IDLE;
                        bus.busy <= 1'b0;
                    end else begin
                        wipe_idx <= wipe_idx + 1'b1;
                    end
                end
                S_IDLE: begin
                    x <= '0;
                    if (bus.sram_re) begin
                        bus.rd_valid   <= 1'b1;
                        bus.sram_color <= acc_rd;
                    end
                    // Clear wins over check; a simultaneous check request is lost.
                    if (bus.clr_req) begin
                        if (int'(bus.clr_y) >= ROWS) begin
                            bus.clr_done <= 1'b1;
                        end else begin
                            bus.busy <= 1'b1;
                            row      <= bus.clr_y;
                            state    <= (bus.clr_y == 6'd0) ? S_FILL_TOP : S_SHIFT_RD;
                        end
                    end else if (bus.chk_req) begin
                        bus.chk_full <= 1'b0;
                        if (int'(bus.chk_y) >= ROWS) begin
                            bus.chk_done <= 1'b1;
                        end else begin
                            bus.busy <= 1'b1;
                            row      <= bus.chk_y;
                            acc      <= 1'b1;
                            state    <= S_CHECK;
                        end
                    end
                end
                S_CHECK: begin
                    if (x == 5'(COLS - 1)) begin
                        bus.chk_done <= 1'b1;
                        bus.chk_full <= acc && (eng_rd != EMPTY);
                        bus.busy     <= 1'b0;
                        state        <= S_IDLE;
                    end else begin
                        acc <= acc && (eng_rd != EMPTY);
                        x   <= x + 5'd1;
                    end
                end
                S_SHIFT_RD: begin
                    latch <= eng_rd;
                    state <= S_SHIFT_WR;
                end
                S_SHIFT_WR: begin
                    state <= S_SHIFT_RD;
                    if (x == 5'(COLS - 1)) begin
                        x <= '0;
                        if (row == 6'd1) state <= S_FILL_TOP;
                        else             row   <= row - 6'd1;
                    end else begin
                        x <= x + 5'd1;
                    end
                end
                S_FILL_TOP: begin
                    if (x == 5'(COLS - 1)) begin
                        bus.clr_done <= 1'b1;
                        state        <= S_DONE;
                    end else begin
                        x <= x + 5'd1;
                    end
                end
                S_DONE: begin
                    bus.busy <= 1'b0;
                    state    <= S_IDLE;
                end
                default: state <= S_WIPE;
            endcase
        end
    end

endmodule

// File: tb/tb_tetris_board_mem.sv
// Testbench for tetris_board_mem: directed scenarios plus randomized traffic,
// compared against a 2-D array model of the playfield.
module tb_tetris_board_mem;

    localparam int         COLS  = 21;
    localparam int         ROWS  = 42;
    localparam int         CELLS = COLS * ROWS;
    localparam logic [2:0] EMPTY = 3'd7;
    localparam logic [2:0] WALL  = 3'd0;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    tetris_board_mem_if bif ();

    tetris_board_mem #(
        .COLS (COLS),
        .ROWS (ROWS),
        .EMPTY(EMPTY),
        .WALL (WALL)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bif)
    );

    int checks = 0;
    int errors = 0;
    int model[ROWS][COLS];
    int clr_pulses = 0;
    int chk_pulses = 0;

    always @(negedge clk) begin
        if (bif.clr_done === 1'b1) clr_pulses++;
        if (bif.chk_done === 1'b1) chk_pulses++;
    end

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
        end
    endtask

    function automatic int mdl_rd(input int x, input int y);
        return (x < COLS && y < ROWS) ? model[y][x] : int'(WALL);
    endfunction

    function automatic void model_wipe();
        for (int y = 0; y < ROWS; y++)
            for (int x = 0; x < COLS; x++) model[y][x] = EMPTY;
    endfunction

    task automatic idle_inputs();
        bif.sram_we = 0; bif.sram_re = 0; bif.curr_x = '0; bif.curr_y = '0; bif.color_w = '0;
        bif.disp_x = '0; bif.disp_y = '0;
        bif.chk_req = 0; bif.chk_y = '0; bif.clr_req = 0; bif.clr_y = '0;
    endtask

    task automatic wr(input int x, input int y, input int c);
        @(negedge clk);
        bif.sram_we = 1; bif.curr_x = 5'(x); bif.curr_y = 6'(y); bif.color_w = 3'(c);
        @(negedge clk);
        bif.sram_we = 0;
        if (x < COLS && y < ROWS) model[y][x] = c;
    endtask

    task automatic rd(input string tag, input int x, input int y);
        @(negedge clk);
        bif.sram_re = 1; bif.curr_x = 5'(x); bif.curr_y = 6'(y);
        @(negedge clk);
        bif.sram_re = 0;
        check_val({tag, "_vld"}, bif.rd_valid, 1);
        check_val({tag, "_dat"}, bif.sram_color, mdl_rd(x, y));
    endtask

    // Write and read of the same cell in one cycle: the read returns the old value.
    task automatic rw(input int x, input int y, input int c);
        int old;
        old = mdl_rd(x, y);
        @(negedge clk);
        bif.sram_we = 1; bif.sram_re = 1; bif.curr_x = 5'(x); bif.curr_y = 6'(y); bif.color_w = 3'(c);
        @(negedge clk);
        bif.sram_we = 0; bif.sram_re = 0;
        check_val("rw_old", bif.sram_color, old);
        if (x < COLS && y < ROWS) model[y][x] = c;
    endtask

    task automatic disp_rd(input int x, input int y);
        @(negedge clk);
        bif.disp_x = 5'(x); bif.disp_y = 6'(y);
        @(negedge clk);
        check_val("disp", bif.disp_color, mdl_rd(x, y));
    endtask

    task automatic run_chk(input int y);
        int  cnt;
        bit  seen;
        int  exp_full;
        exp_full = (y < ROWS) ? 1 : 0;
        if (y < ROWS)
            for (int x = 0; x < COLS; x++) if (model[y][x] == EMPTY) exp_full = 0;
        cnt = 0; seen = 0;
        @(negedge clk);
        bif.chk_req = 1; bif.chk_y = 6'(y);
        while (!seen && cnt < 100) begin
            @(negedge clk);
            bif.chk_req = 0;
            cnt++;
            if (bif.chk_done) seen = 1;
        end
        check_val("chk_lat", cnt, (y < ROWS) ? COLS + 1 : 1);
        check_val("chk_full", bif.chk_full, exp_full);
    endtask

    task automatic run_clr(input int y, input bit junk, input bit with_chk);
        int cnt, nrv, c0, k0, exp_cnt;
        bit seen;
        c0 = clr_pulses; k0 = chk_pulses; cnt = 0; nrv = 0; seen = 0;
        exp_cnt = (y < ROWS) ? 2 * COLS * y + COLS + 1 : 1;
        @(negedge clk);
        bif.clr_req = 1; bif.clr_y = 6'(y);
        bif.chk_req = with_chk; bif.chk_y = 6'($urandom_range(0, ROWS - 1));
        while (!seen && cnt < 4000) begin
            @(negedge clk);
            cnt++;
            if (bif.clr_done) seen = 1;
            if (bif.rd_valid) nrv++;
            if (junk && !seen) begin
                bif.sram_we = 1; bif.sram_re = 1; bif.clr_req = 1; bif.chk_req = 1;
                bif.curr_x  = 5'($urandom_range(0, COLS - 1));
                bif.curr_y  = 6'($urandom_range(0, ROWS - 1));
                bif.color_w = 3'($urandom_range(0, 6));
                bif.clr_y   = 6'($urandom_range(0, ROWS - 1));
                bif.chk_y   = 6'($urandom_range(0, ROWS - 1));
            end else begin
                bif.sram_we = 0; bif.sram_re = 0; bif.clr_req = 0; bif.chk_req = 0;
            end
        end
        bif.sram_we = 0; bif.sram_re = 0; bif.clr_req = 0; bif.chk_req = 0;
        repeat (3) @(negedge clk);
        check_val("clr_lat", cnt, exp_cnt);
        check_val("clr_pulses", clr_pulses - c0, 1);
        check_val("clr_chk_pulses", chk_pulses - k0, 0);
        check_val("clr_rdv", nrv, 0);
        if (y < ROWS) begin
            for (int r = y; r >= 1; r--)
                for (int x = 0; x < COLS; x++) model[r][x] = model[r - 1][x];
            for (int x = 0; x < COLS; x++) model[0][x] = EMPTY;
        end
    endtask

    // Sweeps every cell through the access port (via_acc=1) or the display port,
    // one address per cycle; the result of each address is sampled a cycle later.
    task automatic compare_board(input bit via_acc, input string tag);
        int bad, fx, fy, px, py, obs;
        bad = 0; fx = -1; fy = -1; px = 0; py = 0;
        for (int n = 0; n <= CELLS; n++) begin
            @(negedge clk);
            if (n > 0) begin
                if (via_acc) obs = bif.rd_valid ? int'(bif.sram_color) : 99;
                else         obs = int'(bif.disp_color);
                if (obs != model[py][px]) begin
                    if (bad == 0) begin fx = px; fy = py; end
                    bad++;
                end
            end
            if (n < CELLS) begin
                px = n % COLS; py = n / COLS;
                if (via_acc) begin
                    bif.sram_re = 1; bif.curr_x = 5'(px); bif.curr_y = 6'(py);
                end else begin
                    bif.disp_x = 5'(px); bif.disp_y = 6'(py);
                end
            end else begin
                bif.sram_re = 0;
            end
        end
        check_val($sformatf("%s(first bad x%0d y%0d)", tag, fx, fy), bad, 0);
    endtask

    task automatic release_and_wipe(input string tag);
        int cnt;
        @(negedge clk);
        reset = 0;
        cnt = 0;
        while (bif.busy && cnt < 2000) begin
            @(negedge clk);
            cnt++;
        end
        check_val(tag, cnt, CELLS);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, checks %0d", checks);
        $fatal(1, "watchdog");
    end

    initial begin
        int op, x, y, c, last_fill, holex, c0;
        reset = 1;
        idle_inputs();
        model_wipe();
        repeat (3) @(negedge clk);
        check_val("rst_busy", bif.busy, 1);
        check_val("rst_rdv", bif.rd_valid, 0);
        check_val("rst_sram_color", bif.sram_color, EMPTY);
        check_val("rst_disp_color", bif.disp_color, EMPTY);
        check_val("rst_chk_done", bif.chk_done, 0);
        check_val("rst_chk_full", bif.chk_full, 0);
        check_val("rst_clr_done", bif.clr_done, 0);

        // 1: wipe length and empty board
        release_and_wipe("wipe_cycles");
        compare_board(1'b1, "init_board");

        // 2: access port basics
        wr(5, 10, 2);
        rd("rd_5_10", 5, 10);
        @(negedge clk);
        check_val("rdv_drop", bif.rd_valid, 0);
        rw(5, 10, 4);
        rd("rd_after_rw", 5, 10);
        rd("rd_x_oob", 21, 0);
        rd("rd_y_oob", 0, 42);
        wr(21, 0, 3);
        rd("rd_no_alias", 0, 1);

        // 3: row-full check
        for (int i = 0; i < COLS; i++) wr(i, 41, 1);
        run_chk(41);
        wr(20, 41, 7);
        run_chk(41);
        run_chk(45);

        // 4: clear-and-shift of the bottom row
        wr(20, 41, 1);
        for (int i = 0; i < COLS; i++) wr(i, 40, 3);
        wr(0, 39, 5);
        run_clr(41, 1'b0, 1'b0);
        rd("shift_0_40", 0, 40);
        rd("shift_0_41", 0, 41);
        compare_board(1'b0, "clr41_board");
        run_chk(41);

        // 5: requests while busy and simultaneous requests
        wr(3, 2, 6);
        run_clr(12, 1'b1, 1'b0);
        compare_board(1'b0, "junk_board");
        run_clr(5, 1'b0, 1'b1);
        run_clr(0, 1'b0, 1'b0);
        run_clr(50, 1'b0, 1'b0);

        // Randomized traffic
        last_fill = 41;
        for (int i = 0; i < 200; i++) begin
            op = $urandom_range(0, 99);
            x  = $urandom_range(0, COLS - 1);
            y  = $urandom_range(0, ROWS - 1);
            c  = $urandom_range(0, 7);
            if ($urandom_range(0, 9) == 0) begin
                x = $urandom_range(0, 31);
                y = $urandom_range(0, 63);
            end
            if (op < 35) wr(x, y, c);
            else if (op < 55) rd("rnd_rd", x, y);
            else if (op < 65) rw(x, y, c);
            else if (op < 77) begin
                if (y < ROWS) begin
                    holex = ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, COLS - 1)) : -1;
                    for (int xx = 0; xx < COLS; xx++)
                        wr(xx, y, (xx == holex) ? int'(EMPTY) : int'($urandom_range(0, 6)));
                    last_fill = y;
                end
            end
            else if (op < 87) run_chk($urandom_range(0, 1) ? last_fill : y);
            else if (op < 92) begin
                if (y < ROWS) run_clr(y, 1'($urandom_range(0, 1)), 1'b0);
            end
            else disp_rd(x, y);
        end
        compare_board(1'b0, "rnd_board");

        // 6: reset in the middle of a shift
        for (int i = 0; i < COLS; i++) wr(i, 20, 2);
        c0 = clr_pulses;
        @(negedge clk);
        bif.clr_req = 1; bif.clr_y = 6'd41;
        @(negedge clk);
        bif.clr_req = 0;
        repeat (600) @(negedge clk);
        #2 reset = 1;
        #1 check_val("midrst_busy", bif.busy, 1);
        check_val("midrst_disp", bif.disp_color, EMPTY);
        @(negedge clk);
        release_and_wipe("rewipe_cycles");
        model_wipe();
        compare_board(1'b1, "rewipe_board");
        repeat (3) @(negedge clk);
        check_val("midrst_clr_done", clr_pulses - c0, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/tetris_board_mem.md
Name: tetris_board_mem

Overview:
- Playfield storage responder for the Tetris game controller.
- Services the controller's cell write/read requests: sram_we/sram_re, curr_x/curr_y, color_w in; sram_color back.
- Runs a dedicated display read port for the VGA path.
- Runs two multi-cycle engines on command:
  - row-full check (feeds the controller's row-elimination decision);
  - row clear-and-shift (moves every row above the cleared row down by one).

Parameters:
- COLS, 21, playfield width in cells; x valid range 0..COLS-1.
- ROWS, 42, playfield height in cells; y valid range 0..ROWS-1, row 0 at top.
- EMPTY, 3'd7, colour code of an empty cell (white).
- WALL, 3'd0, colour returned for any out-of-range address; non-EMPTY, so reads as occupied.

Ports:
- clk in 1: single clock, all logic on posedge.
- reset in 1: asynchronous, active-high.
- sram_we in 1: write colour to cell (curr_x, curr_y).
- sram_re in 1: read cell (curr_x, curr_y).
- curr_x in 5: access column.
- curr_y in 6: access row.
- color_w in 3: write colour.
- sram_color out 3: read data.
- rd_valid out 1: sram_color valid this cycle.
- disp_x in 5: display column.
- disp_y in 6: display row.
- disp_color out 3: display read data, 1-cycle latency.
- chk_req in 1: start row-full check, single-cycle pulse.
- chk_y in 6: row to check.
- chk_done out 1: one-cycle pulse when the check finishes.
- chk_full out 1: result, held until the next check starts.
- clr_req in 1: start clear of row clr_y, single-cycle pulse.
- clr_y in 6: row to clear.
- clr_done out 1: one-cycle pulse when the clear finishes.
- busy out 1: engine active; access port and requests ignored.

Behaviour:

Reset (asynchronous):
- Outputs: busy=1, rd_valid=0, sram_color=EMPTY, disp_color=EMPTY, chk_done=0, chk_full=0, clr_done=0.
- FSM goes to S_WIPE.
- Assertion mid-operation aborts any check or shift; the board is rewiped.

States:
- S_WIPE: writes EMPTY to one cell per cycle, x fastest, for ROWS*COLS cycles, then goes to S_IDLE. busy drops on the first S_IDLE cycle.
- S_IDLE: busy=0.
  - Access port active.
  - clr_req has priority over chk_req; a simultaneous chk_req is dropped.
  - Requests arriving while busy=1 are dropped, not queued.
- S_CHECK:
  - Reads row chk_y cells x=0..COLS-1, one per cycle.
  - chk_full = 1 iff every cell != EMPTY.
  - chk_done pulses, with chk_full valid, on the cycle after the last read. Latency is COLS+1 cycles from the chk_req edge.
  - chk_y >= ROWS: chk_done pulses on the next cycle with chk_full=0.
- S_SHIFT_RD / S_SHIFT_WR:
  - Row pointer r starts at clr_y and steps down to 1; x runs 0..COLS-1 within each row.
  - S_SHIFT_RD latches cell (x, r-1); S_SHIFT_WR writes the latched value to (x, r).
  - 2 cycles per cell.
- S_FILL_TOP: writes EMPTY to row 0, one cell per cycle, COLS cycles.
- S_DONE: clr_done=1 for one cycle, then S_IDLE.
- Clear totals:
  - Total clear cycles = 2*COLS*clr_y + COLS + 1.
  - clr_y = 0 skips the shift states.
  - clr_y >= ROWS: no cells change; clr_done pulses on the next cycle.

Access port (S_IDLE only):
- Write: occurs at the clock edge.
- Read: sram_color registered; rd_valid=1 the following cycle only.
- Same-cycle we and re to the same cell: read-before-write (old data).
- Out of range (x >= COLS or y >= ROWS):
  - write ignored;
  - read returns WALL with rd_valid=1.
- While busy: we/re ignored, rd_valid=0, sram_color holds its last value.

Display port:
- Always serviced, including while busy; 1-cycle latency.
- During a shift it shows intermediate content.
- Out of range returns WALL.

Test Plan:
1. Reset release -> busy high exactly 882 cycles (21*42); afterwards every (x,y) read returns 3'd7 with rd_valid one cycle after re.
2. Write color 3'd2 to (5,10), read (5,10) next cycle -> sram_color=3'd2; same-cycle we 3'd4 + re at (5,10) -> returns 3'd2, a later read returns 3'd4; read (21,0) and (0,42) -> 3'd0.
3. Fill row 41 with 3'd1, chk_req chk_y=41 -> chk_done after 22 cycles, chk_full=1; set (20,41)=3'd7, recheck -> chk_full=0.
4. Row 40 all 3'd3, row 41 full, (0,39)=3'd5; clr_req clr_y=41 -> clr_done after 2*21*41+22=1744 cycles; row 41 = 3'd3, (0,40)=3'd5, row 0 all 3'd7.
5. Assert sram_we, chk_req and clr_req during a clear -> no board change, no extra done pulses; simultaneous chk_req+clr_req in idle -> only clr_done fires.
6. Assert reset mid-shift -> busy stays high, wipe restarts, board all 3'd7 after 882 cycles; clr_done never pulses.
